vga_sprite_fetch: RTL and testbench

VGA_SPRITE_FETCH -- requirements
Module: vga_sprite_fetch

---
 rtl/vga_sprite_fetch.sv | 118 +++++++++++
 tb/tb_vga_sprite_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_fetch.sv
// vga_sprite_fetch: ping-pong line-buffered sprite fetcher feeding one layer-selector input.
module vga_sprite_fetch #(
    parameter int          WIDTH       = 32,
    parameter int          HEIGHT      = 32,
    parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [9:0]  VGA_X,
    input  logic        VGA_LINE_START,
    input  logic [9:0]  VGA_NEXT_Y,
    input  logic        SPRITE_EN,
    input  logic [9:0]  SPRITE_X,
    input  logic [9:0]  SPRITE_Y,
    input  logic [19:0] SPRITE_BASE,
    output logic        MEM_REQ,
    output logic [19:0] MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic [15:0] MEM_DATA,
    output logic        VGA_SPRITE_ISOBJ,
    output logic [15:0] VGA_SPRITE_PIXEL,
    output logic        FETCH_BUSY,
    output logic        FETCH_OVERRUN
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state, state_nx;
    logic [15:0] line_buf [2][WIDTH];
    logic [9:0] buf_x [2];
    logic [1:0] buf_valid;
    logic fill_sel, pending;
    logic [CW-1:0] col, off;
    logic [19:0] row_addr;
    logic hit, ack_fire, done, overrun, restart, in_rng, obj;
    logic [9:0] disp_x;
    logic [15:0] disp_pix;

    assign hit = SPRITE_EN && ({1'b0, VGA_NEXT_Y} >= {1'b0, SPRITE_Y})
                 && ({1'b0, VGA_NEXT_Y} < {1'b0, SPRITE_Y} + 11'(HEIGHT));
    assign ack_fire = MEM_REQ && MEM_ACK;
    // A final ACK coinciding with LINE_START still completes the line.
    assign done = state == FETCH && ack_fire && col == CW'(WIDTH - 1);
    assign overrun = VGA_LINE_START && state == FETCH && !done;
    assign restart = state_nx == FETCH && (state != FETCH || VGA_LINE_START);
    assign FETCH_BUSY = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (VGA_LINE_START && hit) ? FETCH : IDLE;
            FETCH:   state_nx = VGA_LINE_START ? ((MEM_REQ && !MEM_ACK) ? DRAIN : (hit ? FETCH : IDLE))
                                               : (done ? IDLE : FETCH);
            DRAIN:   state_nx = !ack_fire ? DRAIN : ((VGA_LINE_START ? hit : pending) ? FETCH : IDLE);
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MEM_REQ       <= 1'b0;
            MEM_ADDR      <= '0;
            col           <= '0;
            buf_valid     <= '0;
            fill_sel      <= 1'b0;
            pending       <= 1'b0;
            row_addr      <= '0;
            FETCH_OVERRUN <= 1'b0;
        end else begin
            FETCH_OVERRUN <= overrun;
            if (restart) begin
                col     <= '0;
                MEM_REQ <= 1'b0;
            end else if (ack_fire) begin
                col     <= col + CW'(1);
                MEM_REQ <= 1'b0;
            end else if (state == FETCH && state_nx == FETCH && !MEM_REQ) begin
                MEM_REQ  <= 1'b1;
                MEM_ADDR <= row_addr + 20'(col);
            end
            if (VGA_LINE_START) begin
                fill_sel              <= !fill_sel;
                buf_valid[fill_sel]   <= buf_valid[fill_sel] || done;
                buf_valid[!fill_sel]  <= 1'b0;
                pending               <= hit;
                row_addr              <= SPRITE_BASE + (20'(VGA_NEXT_Y - SPRITE_Y) << CW);
            end else if (done) begin
                buf_valid[fill_sel] <= 1'b1;
            end
        end
    end

    // Drained words are never written: only FETCH owns the fill buffer.
    always_ff @(posedge CLK) begin
        if (state == FETCH && ack_fire) line_buf[fill_sel][col] <= MEM_DATA;
        if (VGA_LINE_START) buf_x[!fill_sel] <= SPRITE_X;
    end

    assign disp_x   = buf_x[!fill_sel];
    assign off      = CW'(VGA_X - disp_x);
    assign disp_pix = line_buf[!fill_sel][off];
    assign in_rng   = ({1'b0, VGA_X} >= {1'b0, disp_x}) && ({1'b0, VGA_X} < {1'b0, disp_x} + 11'(WIDTH));
    assign obj      = buf_valid[!fill_sel] && in_rng && disp_pix != TRANSPARENT;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            VGA_SPRITE_ISOBJ <= 1'b0;
            VGA_SPRITE_PIXEL <= '0;
        end else begin
            VGA_SPRITE_ISOBJ <= obj;
            VGA_SPRITE_PIXEL <= obj ? disp_pix : 16'h0000;
        end
    end
endmodule

// File: tb/tb_vga_sprite_fetch.sv
// tb_vga_sprite_fetch: scoreboard bench for vga_sprite_fetch with a handshaking memory model.
module tb_vga_sprite_fetch;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [9:0] vga_x = '0, next_y = '0, spr_x = '0, spr_y = '0;
    logic line_start = 1'b0, spr_en = 1'b0, mem_ack = 1'b0;
    logic [19:0] spr_base = '0, mem_addr;
    logic [15:0] mem_data = '0, pixel;
    logic mem_req, isobj, busy, overrun;
    int checks = 0, errors = 0;
    int n_ack = 0, ack_limit = 1 << 30, wait_cnt = 0;
    logic [19:0] exp_addr [$];
    logic [26:0] exp_disp [$];
    logic [19:0] st_exp [$], st_mask [$];
    string st_name [$];
    logic chk_v = 1'b0, chk_d = 1'b0, q_chk = 1'b0, pend_prev = 1'b0;
    logic [19:0] addr_prev = '0;
    localparam logic [19:0] M_REQ = 20'h80000, M_BUSY = 20'h40000, M_OVR = 20'h20000, M_ALL = 20'hFFFFF;

    always #5 clk = ~clk;

    vga_sprite_fetch dut (
        .CLK(clk), .RESET_N(rst_n), .VGA_X(vga_x), .VGA_LINE_START(line_start),
        .VGA_NEXT_Y(next_y), .SPRITE_EN(spr_en), .SPRITE_X(spr_x), .SPRITE_Y(spr_y),
        .SPRITE_BASE(spr_base), .MEM_REQ(mem_req), .MEM_ADDR(mem_addr), .MEM_ACK(mem_ack),
        .MEM_DATA(mem_data), .VGA_SPRITE_ISOBJ(isobj), .VGA_SPRITE_PIXEL(pixel),
        .FETCH_BUSY(busy), .FETCH_OVERRUN(overrun)
    );

    function automatic logic [15:0] mem_word(input logic [19:0] a);
        return (a == 20'h01065) ? 16'hF81F : a[15:0] ^ 16'h1234;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory: acks one cycle after a request is seen, never beyond ack_limit words.
    initial forever begin
        @(posedge clk);
        chk_d = chk_v;
        #2;
        if (mem_ack || !mem_req) begin
            mem_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= 1 && n_ack < ack_limit) begin
            mem_ack = 1'b1;
            mem_data = mem_word(mem_addr);
            n_ack++;
        end else begin
            wait_cnt++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (mem_req && mem_ack) begin
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL addr: unexpected request at %h", mem_addr);
            end else begin
                check("addr", {12'h0, mem_addr}, {12'h0, exp_addr.pop_front()});
            end
        end
        if (rst_n && pend_prev) begin
            check("req_hold", {31'h0, mem_req}, 32'h1);
            check("addr_hold", {12'h0, mem_addr}, {12'h0, addr_prev});
        end
        pend_prev = rst_n && mem_req && !mem_ack;
        addr_prev = mem_addr;
        if (chk_d && exp_disp.size() > 0) begin
            logic [26:0] e;
            e = exp_disp.pop_front();
            check($sformatf("disp_x%0d", e[26:17]), {15'h0, isobj, pixel}, {15'h0, e[16:0]});
        end
        if (q_chk) check("addr_queue_left", exp_addr.size(), 0);
        while (st_exp.size() > 0) begin
            logic [19:0] m;
            m = st_mask.pop_front();
            check(st_name.pop_front(), {12'h0, {mem_req, busy, overrun, isobj, pixel} & m},
                  {12'h0, st_exp.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string nm, input logic [19:0] mask, input logic [19:0] val);
        st_name.push_back(nm);
        st_mask.push_back(mask);
        st_exp.push_back(val);
    endtask

    task automatic line(input logic en, input logic [9:0] x, input logic [9:0] y,
                        input logic [9:0] ny, input logic [19:0] base);
        spr_en = en; spr_x = x; spr_y = y; next_y = ny; spr_base = base;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic push_row(input logic [19:0] row, input int n);
        for (int c = 0; c < n; c++) exp_addr.push_back(row + 20'(c));
    endtask

    task automatic show(input logic [9:0] x, input logic obj, input logic [15:0] pix);
        vga_x = x;
        chk_v = 1'b1;
        exp_disp.push_back({x, obj, pix});
        tick();
        chk_v = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 400 && busy; i++) tick();
        expect_st(nm, M_BUSY, 20'h0);
        q_chk = 1'b1;
        tick();
        q_chk = 1'b0;
    endtask

    task automatic wait_withheld();
        for (int i = 0; i < 300 && !(mem_req && n_ack == ack_limit); i++) tick();
        tick();
    endtask

    initial begin
        repeat (2) tick();
        expect_st("reset_outputs", M_ALL, 20'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic fetch; sprite inputs scrambled mid-fetch must not matter.
        push_row(20'h01040, 32);
        line(1'b1, 10'd100, 10'd50, 10'd52, 20'h01000);
        spr_x = 10'd300; spr_y = 10'd0; spr_base = 20'h0;
        wait_idle("fetch1_done");
        line(1'b0, 10'd0, 10'd0, 10'd0, 20'h0);
        show(10'd99, 1'b0, 16'h0);
        for (int c = 0; c < 32; c++) show(10'(100 + c), 1'b1, mem_word(20'h01040 + 20'(c)));
        show(10'd132, 1'b0, 16'h0);

        // Transparent key at column 5.
        push_row(20'h01060, 32);
        line(1'b1, 10'd100, 10'd50, 10'd53, 20'h01000);
        wait_idle("fetch2_done");
        line(1'b0, 10'd0, 10'd0, 10'd0, 20'h0);
        show(10'd104, 1'b1, mem_word(20'h01064));
        show(10'd105, 1'b0, 16'h0);
        show(10'd106, 1'b1, mem_word(20'h01066));

        // Overrun: column 11 request withheld, LINE_START with a new hit.
        ack_limit = n_ack + 11;
        push_row(20'h01140, 12);
        line(1'b1, 10'd100, 10'd50, 10'd60, 20'h01000);
        wait_withheld();
        expect_st("pre_overrun", M_REQ | M_OVR, M_REQ);
        push_row(20'h01080, 32);
        line(1'b1, 10'd100, 10'd50, 10'd54, 20'h01000);
        expect_st("overrun_pulse", M_REQ | M_BUSY | M_OVR, M_REQ | M_BUSY | M_OVR);
        tick();
        expect_st("overrun_one_cycle", M_REQ | M_OVR, M_REQ);
        show(10'd100, 1'b0, 16'h0);
        show(10'd110, 1'b0, 16'h0);
        ack_limit = n_ack + 1000;
        wait_idle("refetch_done");
        line(1'b0, 10'd0, 10'd0, 10'd0, 20'h0);
        show(10'd100, 1'b1, mem_word(20'h01080));
        show(10'd131, 1'b1, mem_word(20'h0109F));

        // Final ACK on the LINE_START edge.
        ack_limit = n_ack + 31;
        push_row(20'h010A0, 32);
        line(1'b1, 10'd100, 10'd50, 10'd55, 20'h01000);
        wait_withheld();
        ack_limit = ack_limit + 1;
        line(1'b0, 10'd0, 10'd0, 10'd0, 20'h0);
        expect_st("simul_no_overrun", M_OVR | M_BUSY, 20'h0);
        tick();
        expect_st("simul_no_overrun2", M_OVR, 20'h0);
        show(10'd100, 1'b1, mem_word(20'h010A0));
        show(10'd131, 1'b1, mem_word(20'h010BF));
        q_chk = 1'b1;
        tick();
        q_chk = 1'b0;
        ack_limit = 1 << 30;

        // Line miss just past the sprite bottom, then right-edge clipping.
        line(1'b1, 10'd100, 10'd50, 10'd82, 20'h01000);
        expect_st("miss_no_req", M_REQ | M_BUSY, 20'h0);
        tick();
        expect_st("miss_no_req2", M_REQ | M_BUSY, 20'h0);
        tick();
        push_row(20'h013E0, 32);
        line(1'b1, 10'd1000, 10'd50, 10'd81, 20'h01000);
        wait_idle("clip_fetch_done");
        line(1'b0, 10'd0, 10'd0, 10'd0, 20'h0);
        show(10'd999, 1'b0, 16'h0);
        show(10'd1000, 1'b1, mem_word(20'h013E0));
        show(10'd1023, 1'b1, mem_word(20'h013F7));
        show(10'd0, 1'b0, 16'h0);
        show(10'd7, 1'b0, 16'h0);

        // Reset mid-fetch, then recovery.
        push_row(20'h01060, 32);
        line(1'b1, 10'd100, 10'd50, 10'd53, 20'h01000);
        repeat (10) tick();
        rst_n = 1'b0;
        exp_addr.delete();
        expect_st("reset_midfetch", M_ALL, 20'h0);
        tick();
        rst_n = 1'b1;
        tick();
        line(1'b0, 10'd0, 10'd0, 10'd0, 20'h0);
        show(10'd104, 1'b0, 16'h0);
        push_row(20'h01060, 32);
        line(1'b1, 10'd100, 10'd50, 10'd53, 20'h01000);
        wait_idle("refetch_after_reset");
        show(10'd104, 1'b0, 16'h0);
        line(1'b0, 10'd0, 10'd0, 10'd0, 20'h0);
        show(10'd104, 1'b1, mem_word(20'h01064));
        show(10'd105, 1'b0, 16'h0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
